// File: rtl/tcm_arbiter_pkg.sv
// tcm_pkg: shared types and defaults for the TCM arbiter.
// Optional feature macro used by this slice: TCM_ARB_ROUND_ROBIN_EN.
package tcm_pkg;

  localparam int TCM_ADDR_W = 16;  // byte-address width covered by the RAM
  localparam int TCM_TAG_W  = 11;  // data request/response tag width

  // Who owns the response slot in the cycle after a grant.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    IFETCH = 2'd1,
    DATA   = 2'd2
  } tcm_owner_t;

  // Control part of the response register. The tag lives next to it in the
  // top level because its width follows the TAG_W parameter.
  typedef struct packed {
    tcm_owner_t owner;
    logic       half_sel;  // addr[2] of a load: 1 = upper 32 bits
    logic       load;      // response carries RAM read data
    logic       error;     // address fell outside the RAM
  } tcm_resp_t;

  // Steers 4 store byte enables onto the half of the 64-bit RAM word.
  function automatic logic [7:0] tcm_lane_en(input logic hi, input logic [3:0] be);
    return hi ? {be, 4'b0000} : {4'b0000, be};
  endfunction

endpackage

// File: rtl/tcm_arbiter_if.sv
// tcm_arbiter_if: core fetch/data ports and the single RAM port.
// slave = arbiter view, master = core + RAM macro view.
interface tcm_arbiter_if
  import tcm_pkg::*;
#(
  parameter int MEM_ADDR_W = TCM_ADDR_W,
  parameter int TAG_W      = TCM_TAG_W
) ();

  // Instruction-fetch port
  logic                    mem_i_rd_i;
  logic                    mem_i_flush_i;
  logic                    mem_i_invalidate_i;
  logic [31:0]             mem_i_pc_i;
  logic                    mem_i_accept_o;
  logic                    mem_i_valid_o;
  logic                    mem_i_error_o;
  logic [63:0]             mem_i_inst_o;

  // Data port
  logic [31:0]             mem_d_addr_i;
  logic [31:0]             mem_d_data_wr_i;
  logic                    mem_d_rd_i;
  logic [3:0]              mem_d_wr_i;
  logic                    mem_d_cacheable_i;
  logic [TAG_W-1:0]        mem_d_req_tag_i;
  logic                    mem_d_invalidate_i;
  logic                    mem_d_writeback_i;
  logic                    mem_d_flush_i;
  logic                    mem_d_accept_o;
  logic                    mem_d_ack_o;
  logic                    mem_d_error_o;
  logic [31:0]             mem_d_data_rd_o;
  logic [TAG_W-1:0]        mem_d_resp_tag_o;

  // RAM port
  logic [MEM_ADDR_W-4:0]   ram_addr_o;
  logic                    ram_rd_o;
  logic [7:0]              ram_wr_o;
  logic [63:0]             ram_wdata_o;
  logic [63:0]             ram_rdata_i;

  modport slave (
    input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
           mem_d_cacheable_i, mem_d_req_tag_i,
           mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    output mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o,
           mem_d_resp_tag_o,
    output ram_addr_o, ram_rd_o, ram_wr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
           mem_d_cacheable_i, mem_d_req_tag_i,
           mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o,
           mem_d_resp_tag_o,
    input  ram_addr_o, ram_rd_o, ram_wr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/tcm_arbiter_grant.sv
// tcm_arb_grant: picks at most one of fetch / data per cycle.
// Default build: fixed priority, data beats fetch.
// With TCM_ARB_ROUND_ROBIN_EN: on contention the class not granted last wins;
// the pointer moves only on contended grants and resets to "data last".
// Grants are forced low while reset is asserted so accepts read 0 in reset.
module tcm_arb_grant (
`ifdef TCM_ARB_ROUND_ROBIN_EN
  input  logic clk_i,
`endif
  input  logic rst_i,
  input  logic i_req_ifetch,
  input  logic i_req_data,
  output logic o_gnt_ifetch,
  output logic o_gnt_data
);

`ifdef TCM_ARB_ROUND_ROBIN_EN

  logic r_last_data;  // 1: data won the most recent contended cycle
  logic w_contend;

  assign w_contend = i_req_ifetch & i_req_data;

  // Round-robin pointer: flips each time both classes collide.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_last_data <= 1'b1;
    else if (w_contend) r_last_data <= ~r_last_data;
  end

  // Grant decode: uncontended requests always win, collisions follow the pointer.
  always_comb begin
    o_gnt_ifetch = ~rst_i & i_req_ifetch & (~i_req_data   |  r_last_data);
    o_gnt_data   = ~rst_i & i_req_data   & (~i_req_ifetch | ~r_last_data);
  end

`else

  // Grant decode: fixed priority, data first.
  always_comb begin
    o_gnt_data   = ~rst_i & i_req_data;
    o_gnt_ifetch = ~rst_i & i_req_ifetch & ~i_req_data;
  end

`endif

endmodule

// File: rtl/tcm_arbiter.sv
// tcm_arbiter: shares one single-ported 64-bit TCM between fetch and data.
// Drives the RAM in the grant cycle and returns a registered response one
// cycle later. Maintenance requests complete locally (TCM is uncached).
// Arbitration policy selected by TCM_ARB_ROUND_ROBIN_EN (see tcm_arb_grant).
module tcm_arbiter
  import tcm_pkg::*;
#(
  parameter int MEM_ADDR_W = TCM_ADDR_W,
  parameter int TAG_W      = TCM_TAG_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tcm_arbiter_if.slave bus
);

  // Request decode
  logic w_req_ifetch, w_req_data;
  logic w_is_store, w_is_load, w_maint_d;
  logic w_oor_i, w_oor_d;
  logic w_gnt_ifetch, w_gnt_data;

  // Response register
  tcm_resp_t        w_resp_next, r_resp;
  logic [TAG_W-1:0] w_tag_next,  r_tag;
  logic             w_valid_i,   w_ack_d;
  logic [31:0]      w_rdata_half;

  // Fetch maintenance is a no-op: never stalled, no response.
  assign w_req_ifetch = bus.mem_i_rd_i;
  assign w_maint_d    = bus.mem_d_invalidate_i | bus.mem_d_writeback_i | bus.mem_d_flush_i;
  // A store bit wins over a simultaneous load bit.
  assign w_is_store   = |bus.mem_d_wr_i;
  assign w_is_load    = bus.mem_d_rd_i & ~w_is_store;
  assign w_req_data   = bus.mem_d_rd_i | w_is_store | w_maint_d;
  assign w_oor_i      = |bus.mem_i_pc_i[31:MEM_ADDR_W];
  assign w_oor_d      = |bus.mem_d_addr_i[31:MEM_ADDR_W];

  tcm_arb_grant u_grant (
`ifdef TCM_ARB_ROUND_ROBIN_EN
    .clk_i        (clk_i),
`endif
    .rst_i        (rst_i),
    .i_req_ifetch (w_req_ifetch),
    .i_req_data   (w_req_data),
    .o_gnt_ifetch (w_gnt_ifetch),
    .o_gnt_data   (w_gnt_data)
  );

  assign bus.mem_i_accept_o = w_gnt_ifetch;
  assign bus.mem_d_accept_o = w_gnt_data;

  // RAM port mux: strobes only for in-range loads, stores and fetches.
  // NOTE: every output gets a default before the branches so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    bus.ram_addr_o  = '0;
    bus.ram_rd_o    = 1'b0;
    bus.ram_wr_o    = 8'h00;
    bus.ram_wdata_o = '0;
    if (w_gnt_data && !w_oor_d) begin
      if (w_is_store) begin
        bus.ram_addr_o  = bus.mem_d_addr_i[MEM_ADDR_W-1:3];
        bus.ram_wr_o    = tcm_lane_en(bus.mem_d_addr_i[2], bus.mem_d_wr_i);
        bus.ram_wdata_o = {2{bus.mem_d_data_wr_i}};
      end else if (w_is_load) begin
        bus.ram_addr_o  = bus.mem_d_addr_i[MEM_ADDR_W-1:3];
        bus.ram_rd_o    = 1'b1;
      end
    end else if (w_gnt_ifetch && !w_oor_i) begin
      bus.ram_addr_o = bus.mem_i_pc_i[MEM_ADDR_W-1:3];
      bus.ram_rd_o   = 1'b1;
    end
  end

  // Next response-register contents from the grant of this cycle.
  always_comb begin
    w_resp_next = '{owner: NONE, half_sel: 1'b0, load: 1'b0, error: 1'b0};
    w_tag_next  = '0;
    if (w_gnt_data) begin
      w_resp_next.owner    = DATA;
      w_resp_next.half_sel = bus.mem_d_addr_i[2];
      w_resp_next.load     = w_is_load;
      // Maintenance is not a RAM access, so it cannot be out of range.
      w_resp_next.error    = w_oor_d & (w_is_load | w_is_store);
      w_tag_next           = bus.mem_d_req_tag_i;
    end else if (w_gnt_ifetch) begin
      w_resp_next.owner    = IFETCH;
      w_resp_next.load     = 1'b1;
      w_resp_next.error    = w_oor_i;
    end
  end

  // Response register; reset drops any in-flight response without replay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp <= '{owner: NONE, half_sel: 1'b0, load: 1'b0, error: 1'b0};
      r_tag  <= '0;
    end else begin
      r_resp <= w_resp_next;
      r_tag  <= w_tag_next;
    end
  end

  assign w_valid_i    = (r_resp.owner == IFETCH);
  assign w_ack_d      = (r_resp.owner == DATA);
  assign w_rdata_half = r_resp.half_sel ? bus.ram_rdata_i[63:32] : bus.ram_rdata_i[31:0];

  // Response outputs: data fields are zero unless their valid/ack is high.
  always_comb begin
    bus.mem_i_valid_o    = w_valid_i;
    bus.mem_i_error_o    = w_valid_i & r_resp.error;
    bus.mem_i_inst_o     = (w_valid_i && !r_resp.error) ? bus.ram_rdata_i : '0;
    bus.mem_d_ack_o      = w_ack_d;
    bus.mem_d_error_o    = w_ack_d & r_resp.error;
    bus.mem_d_data_rd_o  = (w_ack_d && r_resp.load && !r_resp.error) ? w_rdata_half : '0;
    bus.mem_d_resp_tag_o = w_ack_d ? r_tag : '0;
  end

endmodule

// File: tb/tb_tcm_arbiter.sv
// tb_tcm_arbiter: scoreboard bench for tcm_arbiter. Models the TCM as a byte
// array and the grant rule (TCM_ARB_ROUND_ROBIN_EN aware); expected responses
// are queued at accept time and checked by an independent monitor.
module tb_tcm_arbiter;

  localparam int AW = 16;
  localparam int TW = 11;

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
    logic [10:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t exp_i[$];
  exp_t exp_d[$];

  logic [63:0] ram       [0:8191];  // RAM macro behaviour
  logic [7:0]  ref_bytes [0:65535]; // byte-level reference contents
  logic        rr_last_data = 1'b1;
  logic        last_gi, last_gd;

  tcm_arbiter_if #(.MEM_ADDR_W(AW), .TAG_W(TW)) bus ();

  tcm_arbiter #(.MEM_ADDR_W(AW), .TAG_W(TW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM macro: one-cycle read latency, byte-enable writes.
  always @(posedge clk) begin
    if (bus.ram_rd_o) bus.ram_rdata_i <= ram[bus.ram_addr_o];
    for (int k = 0; k < 8; k++)
      if (bus.ram_wr_o[k]) ram[bus.ram_addr_o][8*k +: 8] <= bus.ram_wdata_o[8*k +: 8];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every response the DUT presents against the queues.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic want;
    want = (exp_i.size() > 0) && (exp_i[0].due == cyc);
    check("i_valid", bus.mem_i_valid_o, want);
    if (want) begin
      e = exp_i.pop_front();
      if (bus.mem_i_valid_o) begin
        check("i_inst",  bus.mem_i_inst_o,  e.data);
        check("i_error", bus.mem_i_error_o, e.err);
      end
    end
    want = (exp_d.size() > 0) && (exp_d[0].due == cyc);
    check("d_ack", bus.mem_d_ack_o, want);
    if (want) begin
      e = exp_d.pop_front();
      if (bus.mem_d_ack_o) begin
        check("d_data",  bus.mem_d_data_rd_o,  e.data[31:0]);
        check("d_error", bus.mem_d_error_o,    e.err);
        check("d_tag",   bus.mem_d_resp_tag_o, e.tag);
      end
    end
  end

  // One clock of stimulus: model the grant, check accept and RAM strobes,
  // queue expected responses, then advance to just after the next edge.
  task automatic step();
    logic req_i, req_d, gi, gd, st, ld, oor;
    logic [7:0]  exp_wr;
    logic [63:0] exp_wdata;
    logic [12:0] exp_addr;
    logic        exp_rd;
    logic [31:0] a;
    int base;
    exp_t e;
    @(negedge clk);
    st    = (bus.mem_d_wr_i != 4'h0);
    ld    = bus.mem_d_rd_i && !st;
    req_i = bus.mem_i_rd_i;
    req_d = bus.mem_d_rd_i || st || bus.mem_d_invalidate_i ||
            bus.mem_d_writeback_i || bus.mem_d_flush_i;
`ifdef TCM_ARB_ROUND_ROBIN_EN
    if (req_i && req_d) begin
      gi = rr_last_data;
      gd = !rr_last_data;
      rr_last_data = gd;
    end else begin
      gi = req_i;
      gd = req_d;
    end
`else
    gd = req_d;
    gi = req_i && !req_d;
`endif
    check("accept_i", bus.mem_i_accept_o, gi);
    check("accept_d", bus.mem_d_accept_o, gd);
    exp_rd = 1'b0; exp_wr = 8'h00; exp_addr = '0; exp_wdata = '0;
    e.due = cyc + 1; e.data = '0; e.err = 1'b0; e.tag = '0;
    if (gd) begin
      a     = bus.mem_d_addr_i;
      oor   = (a >= 32'h0001_0000);
      e.tag = bus.mem_d_req_tag_i;
      e.err = oor && (ld || st);
      base  = int'(a & 32'h0000_FFFC);
      if (!oor && st) begin
        exp_wr    = 8'({4'h0, bus.mem_d_wr_i} << (a[2] ? 4 : 0));
        exp_addr  = 13'(a / 8);
        exp_wdata = {bus.mem_d_data_wr_i, bus.mem_d_data_wr_i};
        for (int b = 0; b < 4; b++)
          if (bus.mem_d_wr_i[b]) ref_bytes[base + b] = bus.mem_d_data_wr_i[8*b +: 8];
      end else if (!oor && ld) begin
        exp_rd   = 1'b1;
        exp_addr = 13'(a / 8);
        for (int b = 0; b < 4; b++) e.data[8*b +: 8] = ref_bytes[base + b];
      end
      exp_d.push_back(e);
    end else if (gi) begin
      a     = bus.mem_i_pc_i;
      oor   = (a >= 32'h0001_0000);
      e.err = oor;
      if (!oor) begin
        exp_rd   = 1'b1;
        exp_addr = 13'(a / 8);
        base     = int'(a & 32'h0000_FFF8);
        for (int b = 0; b < 8; b++) e.data[8*b +: 8] = ref_bytes[base + b];
      end
      exp_i.push_back(e);
    end
    check("ram_rd", bus.ram_rd_o, exp_rd);
    check("ram_wr", bus.ram_wr_o, exp_wr);
    if (exp_rd || exp_wr != 8'h00) check("ram_addr", bus.ram_addr_o, exp_addr);
    if (exp_wr != 8'h00) check("ram_wdata", bus.ram_wdata_o, exp_wdata);
    last_gi = gi;
    last_gd = gd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_i_rd_i = 1'b0; bus.mem_i_flush_i = 1'b0; bus.mem_i_invalidate_i = 1'b0;
    bus.mem_d_rd_i = 1'b0; bus.mem_d_wr_i = 4'h0;
    bus.mem_d_invalidate_i = 1'b0; bus.mem_d_writeback_i = 1'b0; bus.mem_d_flush_i = 1'b0;
  endtask

  task automatic data_req(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [10:0] tag);
    bus.mem_d_rd_i = rd; bus.mem_d_wr_i = wr; bus.mem_d_addr_i = addr;
    bus.mem_d_data_wr_i = wdata; bus.mem_d_req_tag_i = tag;
  endtask

  initial begin : stim
    logic pend_i, pend_d;
    int r;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_bytes[8*i + b] = ram[i][8*b +: 8];
    end
    bus.ram_rdata_i = '0;
    bus.mem_d_cacheable_i = 1'b0;

    // Reset with every request high: all outputs must read 0.
    bus.mem_i_rd_i = 1'b1; bus.mem_i_flush_i = 1'b1; bus.mem_i_invalidate_i = 1'b1;
    bus.mem_i_pc_i = 32'h10;
    data_req(1'b1, 4'hF, 32'h24, 32'h1234_5678, 11'h1);
    bus.mem_d_invalidate_i = 1'b1; bus.mem_d_writeback_i = 1'b1; bus.mem_d_flush_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_i",  bus.mem_i_accept_o,   0);
    check("rst_acc_d",  bus.mem_d_accept_o,   0);
    check("rst_valid",  bus.mem_i_valid_o,    0);
    check("rst_ierr",   bus.mem_i_error_o,    0);
    check("rst_inst",   bus.mem_i_inst_o,     0);
    check("rst_ack",    bus.mem_d_ack_o,      0);
    check("rst_derr",   bus.mem_d_error_o,    0);
    check("rst_drd",    bus.mem_d_data_rd_o,  0);
    check("rst_tag",    bus.mem_d_resp_tag_o, 0);
    check("rst_raddr",  bus.ram_addr_o,       0);
    check("rst_rrd",    bus.ram_rd_o,         0);
    check("rst_rwr",    bus.ram_wr_o,         0);
    check("rst_rwdata", bus.ram_wdata_o,      0);
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Fetch pc=0x10 returns doubleword index 2.
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h10;
    step();
    idle_inputs();
    step();

    // Store then load at 0x24 (upper half of doubleword 4).
    data_req(1'b0, 4'hF, 32'h24, 32'hDEAD_BEEF, 11'h05);
    step();
    data_req(1'b1, 4'h0, 32'h24, 32'h0, 11'h06);
    step();
    idle_inputs();
    step();

    // Contention: fetch held while a load is issued each cycle.
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = 32'h40;
    for (int i = 0; i < 4; i++) begin
      data_req(1'b1, 4'h0, 32'h100 + 32'(8 * i), 32'h0, 11'(16 + i));
      step();
    end
    data_req(1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
    step();
    idle_inputs();
    step();

    // Out-of-range load and a local maintenance request.
    data_req(1'b1, 4'h0, 32'h0001_0000, 32'h0, 11'h01);
    step();
    idle_inputs();
    bus.mem_d_flush_i = 1'b1; bus.mem_d_req_tag_i = 11'h7FF;
    step();
    idle_inputs();
    step();

    // Reset during the response cycle drops ack at once and nothing replays.
    data_req(1'b1, 4'h0, 32'h24, 32'h0, 11'h09);
    step();
    idle_inputs();
    check("pre_rst_ack", bus.mem_d_ack_o, 1);
    #1 rst = 1'b1;
    #1 check("rst_ack_drop", bus.mem_d_ack_o, 0);
    exp_i.delete();
    exp_d.delete();
    rr_last_data = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();

    // Random traffic; ungranted requests are held until accepted.
    pend_i = 1'b0;
    pend_d = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend_i) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.mem_i_rd_i = 1'b1;
          bus.mem_i_pc_i = ($urandom_range(0, 7) == 0) ?
                           (32'($urandom_range(1, 65535)) << 16) | 32'($urandom_range(0, 65535)) :
                           32'($urandom_range(0, 1023));
          pend_i = 1'b1;
        end else bus.mem_i_rd_i = 1'b0;
      end
      if (!pend_d) begin
        bus.mem_d_invalidate_i = 1'b0; bus.mem_d_writeback_i = 1'b0; bus.mem_d_flush_i = 1'b0;
        data_req(1'b0, 4'h0,
                 ($urandom_range(0, 7) == 0) ?
                   (32'($urandom_range(1, 65535)) << 16) | 32'($urandom_range(0, 1023)) :
                   32'($urandom_range(0, 1023)),
                 $urandom, 11'($urandom_range(0, 2047)));
        r = $urandom_range(0, 9);
        pend_d = (r != 9);
        if (r <= 3) bus.mem_d_rd_i = 1'b1;
        else if (r <= 6) bus.mem_d_wr_i = 4'($urandom_range(1, 15));
        else if (r == 7) begin
          bus.mem_d_rd_i = 1'b1;
          bus.mem_d_wr_i = 4'($urandom_range(1, 15));
        end else if (r == 8) begin
          case ($urandom_range(0, 2))
            0:       bus.mem_d_invalidate_i = 1'b1;
            1:       bus.mem_d_writeback_i  = 1'b1;
            default: bus.mem_d_flush_i      = 1'b1;
          endcase
        end
      end
      bus.mem_i_flush_i      = 1'($urandom_range(0, 1));
      bus.mem_i_invalidate_i = 1'($urandom_range(0, 1));
      bus.mem_d_cacheable_i  = 1'($urandom_range(0, 1));
      step();
      if (last_gi) pend_i = 1'b0;
      if (last_gd) pend_d = 1'b0;
    end

    idle_inputs();
    repeat (2) step();
    check("drain_i", 64'(exp_i.size()), 0);
    check("drain_d", 64'(exp_d.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
